// File: rtl/mdl_serial_modcntr.sv
// mdl_serial_modcntr: bit-serial modular page counter, +/-STEP per frame, result kept in [0, MODULUS-1]
// Ports: i_MCLK clock, i_RST async reset (high), i_CEN_n tick enable (low),
//   i_FRAME_START/i_LOAD/i_LOAD_VAL frame and load requests, i_CNT_START/i_CNT_STOP add-enable,
//   i_DIR 0=up 1=down, i_SER_GATE write-back gate; o_SER_LSB serial sum bit, o_VALUE committed value,
//   o_BUSY in SHIFT, o_FRAME_DONE/o_WRAP frame-end pulse and wrap flag, o_LOAD_ERR rejected load pulse.
module mdl_serial_modcntr #(
  parameter int WIDTH   = 12,
  parameter int MODULUS = 2053,
  parameter int STEP    = 522
) (
  input  logic             i_MCLK,
  input  logic             i_RST,
  input  logic             i_CEN_n,
  input  logic             i_FRAME_START,
  input  logic             i_CNT_START,
  input  logic             i_CNT_STOP,
  input  logic             i_DIR,
  input  logic             i_LOAD,
  input  logic [WIDTH-1:0] i_LOAD_VAL,
  input  logic             i_SER_GATE,
  output logic             o_SER_LSB,
  output logic [WIDTH-1:0] o_VALUE,
  output logic             o_BUSY,
  output logic             o_FRAME_DONE,
  output logic             o_WRAP,
  output logic             o_LOAD_ERR
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] K_UP  = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] K_UPW = WIDTH'(STEP - MODULUS);
  localparam logic [WIDTH-1:0] K_DN  = WIDTH'(-STEP);
  localparam logic [WIDTH-1:0] UP_TH = WIDTH'(MODULUS - STEP);
  localparam logic [WIDTH-1:0] DN_TH = WIDTH'(STEP);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d, value_q, value_d, k_q, k_d;
  logic [CW-1:0]    bit_q, bit_d;
  logic             carry_q, carry_d, en_q, en_d, up_q, up_d, dn_q, dn_d;
  logic             ge_q, ge_d, lt_q, lt_d, wsel_q, wsel_d;
  logic             ser_q, ser_d, done_q, done_d, wrap_q, wrap_d, lerr_q, lerr_d;
  logic             tick, last, load_ok, s, wb;
  always_comb begin
    tick    = ~i_CEN_n;
    last    = bit_q == CW'(WIDTH - 1);
    load_ok = {1'b0, i_LOAD_VAL} < (WIDTH + 1)'(MODULUS);
    s       = sr_q[0] ^ k_q[0] ^ carry_q;
    wb      = s & i_SER_GATE;
    state_d = state_q;
    sr_d    = sr_q;
    value_d = value_q;
    k_d     = k_q;
    bit_d   = bit_q;
    carry_d = carry_q;
    up_d    = up_q;
    dn_d    = dn_q;
    ge_d    = ge_q;
    lt_d    = lt_q;
    wsel_d  = wsel_q;
    ser_d   = ser_q;
    done_d  = 1'b0;
    wrap_d  = 1'b0;
    lerr_d  = 1'b0;
    en_d    = tick ? (i_CNT_STOP ? 1'b0 : (i_CNT_START ? 1'b1 : en_q)) : en_q;
    if (tick && state_q == IDLE) begin
      ser_d = 1'b0;
      if (i_LOAD) begin
        sr_d    = load_ok ? i_LOAD_VAL : sr_q;
        value_d = load_ok ? i_LOAD_VAL : value_q;
        up_d    = load_ok ? i_LOAD_VAL >= UP_TH : up_q;
        dn_d    = load_ok ? i_LOAD_VAL < DN_TH : dn_q;
        lerr_d  = ~load_ok;
      end else if (i_FRAME_START) begin
        state_d = SHIFT;
        bit_d   = '0;
        carry_d = 1'b0;
        k_d     = ~en_q ? '0 : (i_DIR ? (dn_q ? UP_TH : K_DN) : (up_q ? K_UPW : K_UP));
        wsel_d  = en_q & (i_DIR ? dn_q : up_q);
        ge_d    = 1'b1;
        lt_d    = 1'b0;
      end
    end else if (tick) begin
      // LSB-first compares: a differing higher bit overrides the verdict from lower bits
      carry_d = (sr_q[0] & k_q[0]) | (carry_q & (sr_q[0] ^ k_q[0]));
      ser_d   = wb;
      sr_d    = {wb, sr_q[WIDTH-1:1]};
      k_d     = k_q >> 1;
      ge_d    = (wb & ~UP_TH[bit_q]) | (~(wb ^ UP_TH[bit_q]) & ge_q);
      lt_d    = (~wb & DN_TH[bit_q]) | (~(wb ^ DN_TH[bit_q]) & lt_q);
      bit_d   = bit_q + 1'b1;
      state_d = last ? IDLE : SHIFT;
      value_d = last ? sr_d : value_q;
      up_d    = last ? ge_d : up_q;
      dn_d    = last ? lt_d : dn_q;
      done_d  = last;
      wrap_d  = last & wsel_q;
    end
  end
  always_ff @(posedge i_MCLK or posedge i_RST) begin
    if (i_RST) begin
      state_q <= IDLE;
      sr_q    <= '0;
      value_q <= '0;
      k_q     <= '0;
      bit_q   <= '0;
      carry_q <= 1'b0;
      en_q    <= 1'b0;
      up_q    <= 1'b0;
      dn_q    <= 1'b1;
      ge_q    <= 1'b0;
      lt_q    <= 1'b0;
      wsel_q  <= 1'b0;
      ser_q   <= 1'b0;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
      lerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      value_q <= value_d;
      k_q     <= k_d;
      bit_q   <= bit_d;
      carry_q <= carry_d;
      en_q    <= en_d;
      up_q    <= up_d;
      dn_q    <= dn_d;
      ge_q    <= ge_d;
      lt_q    <= lt_d;
      wsel_q  <= wsel_d;
      ser_q   <= ser_d;
      done_q  <= done_d;
      wrap_q  <= wrap_d;
      lerr_q  <= lerr_d;
    end
  end
  assign o_SER_LSB    = ser_q;
  assign o_VALUE      = value_q;
  assign o_BUSY       = state_q == SHIFT;
  assign o_FRAME_DONE = done_q;
  assign o_WRAP       = wrap_q;
  assign o_LOAD_ERR   = lerr_q;
endmodule

// File: tb/tb_mdl_serial_modcntr.sv
// tb_mdl_serial_modcntr: scoreboard bench for mdl_serial_modcntr against an arithmetic model
module tb_mdl_serial_modcntr;
  localparam int W = 12;
  localparam int M = 2053;
  localparam int S = 522;
  logic         clk = 1'b0;
  logic         i_RST = 1'b0, i_CEN_n = 1'b0, i_FRAME_START = 1'b0, i_CNT_START = 1'b0;
  logic         i_CNT_STOP = 1'b0, i_DIR = 1'b0, i_LOAD = 1'b0, i_SER_GATE = 1'b1;
  logic [W-1:0] i_LOAD_VAL = '0;
  logic         o_SER_LSB, o_BUSY, o_FRAME_DONE, o_WRAP, o_LOAD_ERR;
  logic [W-1:0] o_VALUE;
  int           checks = 0, errors = 0;
  int           v = 0;
  bit           en = 0;
  logic [W+1:0] sb[$];
  logic [W+1:0] e;
  mdl_serial_modcntr #(.WIDTH(W), .MODULUS(M), .STEP(S)) dut (
    .i_MCLK(clk), .i_RST(i_RST), .i_CEN_n(i_CEN_n), .i_FRAME_START(i_FRAME_START),
    .i_CNT_START(i_CNT_START), .i_CNT_STOP(i_CNT_STOP), .i_DIR(i_DIR), .i_LOAD(i_LOAD),
    .i_LOAD_VAL(i_LOAD_VAL), .i_SER_GATE(i_SER_GATE), .o_SER_LSB(o_SER_LSB), .o_VALUE(o_VALUE),
    .o_BUSY(o_BUSY), .o_FRAME_DONE(o_FRAME_DONE), .o_WRAP(o_WRAP), .o_LOAD_ERR(o_LOAD_ERR));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    if (!i_RST && (o_FRAME_DONE || o_LOAD_ERR)) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: done=%b load_err=%b expected none", o_FRAME_DONE, o_LOAD_ERR);
      end else begin
        e = sb.pop_front();
        chk("sb_kind", o_LOAD_ERR, e[W+1]);
        chk("sb_done", o_FRAME_DONE, !e[W+1]);
        chk("sb_wrap", o_WRAP, e[W]);
        chk("sb_value", o_VALUE, e[W-1:0]);
      end
    end
  end
  task automatic do_reset();
    @(posedge clk);
    #3 i_RST = 1'b1;
    #1;
    chk("rst_value", o_VALUE, 0);
    chk("rst_busy", o_BUSY, 0);
    chk("rst_ser", o_SER_LSB, 0);
    chk("rst_done", o_FRAME_DONE, 0);
    chk("rst_wrap", o_WRAP, 0);
    chk("rst_lerr", o_LOAD_ERR, 0);
    @(posedge clk);
    @(posedge clk);
    #1 i_RST = 1'b0;
    v = 0;
    en = 0;
  endtask
  task automatic set_en(input bit start, input bit stop);
    i_CNT_START = start;
    i_CNT_STOP = stop;
    @(posedge clk);
    #1;
    i_CNT_START = 1'b0;
    i_CNT_STOP = 1'b0;
    en = stop ? 0 : (start ? 1 : en);
  endtask
  task automatic do_load(input int val, input bit with_start);
    i_LOAD = 1'b1;
    i_LOAD_VAL = val[W-1:0];
    i_FRAME_START = with_start;
    if (val >= M) sb.push_back({1'b1, 1'b0, v[W-1:0]});
    else v = val;
    @(posedge clk);
    #1;
    i_LOAD = 1'b0;
    i_FRAME_START = 1'b0;
    chk("load_value", o_VALUE, v);
    chk("load_busy", o_BUSY, 0);
  endtask
  task automatic do_frame(input bit dir, input bit gate, input bit freeze);
    int nv, ticks;
    bit w, done, cen_was;
    logic [W-1:0] ser;
    w = en && (dir ? v < S : v + S >= M);
    nv = !en ? v : (dir ? (v - S + M) % M : (v + S) % M);
    if (!gate) nv = 0;
    sb.push_back({1'b0, w, nv[W-1:0]});
    i_DIR = dir;
    i_SER_GATE = gate;
    i_FRAME_START = 1'b1;
    @(posedge clk);
    #1;
    i_FRAME_START = 1'b0;
    chk("frame_busy", o_BUSY, 1);
    ticks = 0;
    done = 0;
    ser = '0;
    for (int n = 1; n <= 40 && !done; n++) begin
      if (freeze) i_CEN_n = (n >= 4 && n < 9);
      cen_was = i_CEN_n;
      @(posedge clk);
      #1;
      if (!cen_was) begin
        ticks++;
        if (ticks <= W) ser[ticks-1] = o_SER_LSB;
      end
      if (o_FRAME_DONE) done = 1;
    end
    i_CEN_n = 1'b0;
    i_SER_GATE = 1'b1;
    chk("frame_seen", done, 1);
    chk("frame_ticks", ticks, W);
    chk("ser_stream", ser, nv);
    chk("frame_idle", o_BUSY, 0);
    v = nv;
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    errors++;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
  initial begin
    do_reset();
    set_en(1, 0);
    repeat (4) do_frame(0, 1, 0);
    chk("up4_value", o_VALUE, 35);
    do_reset();
    set_en(1, 0);
    do_frame(1, 1, 0);
    do_frame(1, 1, 0);
    chk("down2_value", o_VALUE, 1009);
    do_load(2052, 0);
    do_frame(0, 1, 0);
    chk("wrap_from_top", o_VALUE, 521);
    do_load(2053, 0);
    do_load(100, 1);
    repeat (16) @(posedge clk);
    #1 chk("load_no_frame", o_VALUE, 100);
    set_en(1, 1);
    do_frame(0, 1, 0);
    chk("disabled_frame", o_VALUE, 100);
    set_en(1, 0);
    do_load(1566, 0);
    do_frame(0, 1, 0);
    do_load(1566, 0);
    do_frame(1, 1, 0);
    chk("dir_toggle", o_VALUE, 1044);
    do_load(1566, 0);
    do_frame(0, 0, 0);
    do_frame(0, 1, 0);
    chk("after_gate", o_VALUE, 522);
    i_DIR = 1'b0;
    i_FRAME_START = 1'b1;
    @(posedge clk);
    #1 i_FRAME_START = 1'b0;
    repeat (7) @(posedge clk);
    #2 i_RST = 1'b1;
    #1;
    chk("abort_value", o_VALUE, 0);
    chk("abort_busy", o_BUSY, 0);
    repeat (2) @(posedge clk);
    #1 i_RST = 1'b0;
    v = 0;
    en = 0;
    repeat (16) @(posedge clk);
    set_en(1, 0);
    do_load(1500, 0);
    do_frame(0, 1, 1);
    chk("freeze_value", o_VALUE, 2022);
    for (int i = 0; i < 40; i++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r == 0) set_en($urandom_range(0, 1), $urandom_range(0, 3) == 0);
      else if (r == 1) do_load($urandom_range(0, 4095), 0);
      else do_frame($urandom_range(0, 1), $urandom_range(0, 7) != 0, r == 9);
    end
    repeat (5) @(posedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
